// File: rtl/aibnd_rambit_pkg.sv
// Shared types and parameter limits for the rambit serial configuration controller.
package aibnd_rambit_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StUpdate = 2'd2,
    StDone   = 2'd3
  } rb_state_e;

  localparam int unsigned ChainLenMin = 1;
  localparam int unsigned ChainLenMax = 1023;
  localparam int unsigned WordWMin    = 1;
  localparam int unsigned WordWMax    = 32;

endpackage

// File: rtl/aibnd_rambit_cfg_ctl.sv
// Serialises host configuration words onto a rambit scan chain, LSB first,
// then strobes scan_update once the whole chain has been shifted.
module aibnd_rambit_cfg_ctl
  import aibnd_rambit_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              i_cfg_avmm_clk,
  input  logic              i_cfg_avmm_rst_n,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_wdata,
  input  logic              cfg_wvalid,
  output logic              cfg_wready,
  output logic              scan_data,
  output logic              scan_shift_en,
  output logic              scan_update,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int unsigned BlW   = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PendW = $clog2(WORD_W + 1);

  if (CHAIN_LEN < ChainLenMin || CHAIN_LEN > ChainLenMax ||
      WORD_W < WordWMin || WORD_W > WordWMax) begin : g_bad_param
    $error("aibnd_rambit_cfg_ctl: CHAIN_LEN or WORD_W out of range");
  end

  rb_state_e         state_q, state_d;
  logic [BlW-1:0]    bits_left_q, bits_left_d;
  logic [PendW-1:0]  pend_q, pend_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              err_q, err_d;
  logic              accept;
  logic              busy;
  logic [PendW-1:0]  n_bits;

  assign busy = (state_q == StShift) || (state_q == StUpdate);

  assign cfg_wready = (state_q == StShift) && (bits_left_q != '0) &&
                      (pend_q <= PendW'(1)) && !cfg_start;
  assign accept     = cfg_wvalid && cfg_wready;

  // Last word may be partial: only bits_left of its bits reach the chain.
  always_comb begin
    if (32'(bits_left_q) >= WORD_W) begin
      n_bits = PendW'(WORD_W);
    end else begin
      n_bits = PendW'(bits_left_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    pend_d      = pend_q;
    sreg_d      = sreg_q;
    err_d       = cfg_wvalid && ((state_q == StIdle) || (state_q == StDone));

    if (cfg_start) begin
      state_d     = StShift;
      bits_left_d = BlW'(CHAIN_LEN);
      pend_d      = '0;
      err_d       = err_d || busy;
    end else begin
      unique case (state_q)
        StShift: begin
          if (pend_q != '0) begin
            sreg_d = sreg_q >> 1;
            pend_d = pend_q - PendW'(1);
          end
          // A reload on the last pending bit keeps the chain shifting gap-free.
          if (accept) begin
            sreg_d      = cfg_wdata;
            pend_d      = n_bits;
            bits_left_d = bits_left_q - BlW'(n_bits);
          end
          if (bits_left_d == '0 && pend_d == '0) begin
            state_d = StUpdate;
          end
        end
        StUpdate: state_d = StDone;
        StIdle:   ;
        StDone:   ;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      state_q     <= StIdle;
      bits_left_q <= '0;
      pend_q      <= '0;
      sreg_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      pend_q      <= pend_d;
      sreg_q      <= sreg_d;
      err_q       <= err_d;
    end
  end

  assign scan_data     = sreg_q[0];
  assign scan_shift_en = (pend_q != '0);
  assign scan_update   = (state_q == StUpdate);
  assign cfg_busy      = busy;
  assign cfg_done      = (state_q == StDone);
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_aibnd_rambit_cfg_ctl.sv
// Directed bench for aibnd_rambit_cfg_ctl with CHAIN_LEN=20, WORD_W=8.
module tb_aibnd_rambit_cfg_ctl;

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic [7:0] cfg_wdata;
  logic       cfg_wvalid;
  logic       cfg_wready;
  logic       scan_data;
  logic       scan_shift_en;
  logic       scan_update;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the monitor process.
  int   cyc = 0;
  int   sh_cnt = 0;
  int   upd_cnt = 0;
  int   err_cnt = 0;
  int   upd_cyc = 0;
  logic got_bit [0:1023];
  int   sh_cyc [0:1023];

  localparam logic [31:0] ExpBits = 32'h000F_3CA5;

  aibnd_rambit_cfg_ctl #(
    .CHAIN_LEN(20),
    .WORD_W   (8)
  ) u_dut (
    .i_cfg_avmm_clk  (clk),
    .i_cfg_avmm_rst_n(rst_n),
    .cfg_start       (cfg_start),
    .cfg_wdata       (cfg_wdata),
    .cfg_wvalid      (cfg_wvalid),
    .cfg_wready      (cfg_wready),
    .scan_data       (scan_data),
    .scan_shift_en   (scan_shift_en),
    .scan_update     (scan_update),
    .cfg_busy        (cfg_busy),
    .cfg_done        (cfg_done),
    .cfg_err         (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc = cyc + 1;
      if (scan_shift_en && sh_cnt < 1024) begin
        got_bit[sh_cnt] = scan_data;
        sh_cyc[sh_cnt]  = cyc;
        sh_cnt = sh_cnt + 1;
      end
      if (scan_update) begin
        upd_cnt = upd_cnt + 1;
        upd_cyc = cyc;
      end
      if (cfg_err) err_cnt = err_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (!cfg_wready && n < 50) begin
      tick();
      n++;
    end
    check_eq("wready_timeout", 32'(cfg_wready), 32'd1);
  endtask

  task automatic send_word(input logic [7:0] w);
    cfg_wvalid = 1'b1;
    cfg_wdata  = w;
    wait_ready();
    tick();
    cfg_wvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!cfg_done && n < 100) begin
      tick();
      n++;
    end
    check_eq("done_timeout", 32'(cfg_done), 32'd1);
  endtask

  function automatic logic [31:0] bits_from(input int base);
    logic [31:0] v = '0;
    for (int i = 0; i < 20; i++) begin
      if (base + i < 1024) v[i] = got_bit[base + i];
    end
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({cfg_wready, scan_data, scan_shift_en, scan_update, cfg_busy, cfg_done, cfg_err});
  endfunction

  initial begin
    int b_sh, b_upd, b_err;
    rst_n      = 1'b0;
    cfg_start  = 1'b0;
    cfg_wdata  = 8'h00;
    cfg_wvalid = 1'b0;

    // Reset state
    #12;
    check_eq("reset_outs", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy_done", 32'({cfg_busy, cfg_done}), 32'd0);

    // Write in IDLE: error pulse, word dropped
    cfg_wvalid = 1'b1;
    cfg_wdata  = 8'h55;
    #1;
    check_eq("idle_wready", 32'(cfg_wready), 32'd0);
    tick();
    cfg_wvalid = 1'b0;
    check_eq("idle_wr_err", 32'(cfg_err), 32'd1);
    tick();
    check_eq("idle_err_pulse", 32'(cfg_err), 32'd0);

    // Normal back-to-back load
    b_sh = sh_cnt; b_upd = upd_cnt; b_err = err_cnt;
    pulse_start();
    check_eq("start_busy", 32'(cfg_busy), 32'd1);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hFF);
    wait_done();
    check_eq("norm_bits", bits_from(b_sh), ExpBits);
    check_eq("norm_count", 32'(sh_cnt - b_sh), 32'd20);
    check_eq("norm_contig", 32'(sh_cyc[b_sh + 19] - sh_cyc[b_sh] + 1), 32'd20);
    check_eq("norm_upd_cnt", 32'(upd_cnt - b_upd), 32'd1);
    check_eq("norm_upd_cyc", 32'(upd_cyc - sh_cyc[b_sh + 19]), 32'd1);
    check_eq("norm_err", 32'(err_cnt - b_err), 32'd0);
    check_eq("norm_busy", 32'(cfg_busy), 32'd0);

    // Two-cycle stall between first and second words
    b_sh = sh_cnt; b_upd = upd_cnt;
    pulse_start();
    send_word(8'hA5);
    wait_ready();
    tick();
    tick();
    send_word(8'h3C);
    send_word(8'hFF);
    wait_done();
    check_eq("stall_bits", bits_from(b_sh), ExpBits);
    check_eq("stall_count", 32'(sh_cnt - b_sh), 32'd20);
    check_eq("stall_gap", 32'(sh_cyc[b_sh + 19] - sh_cyc[b_sh] + 1 - 20), 32'd2);
    check_eq("stall_upd_cnt", 32'(upd_cnt - b_upd), 32'd1);

    // Write while DONE
    b_sh = sh_cnt;
    cfg_wvalid = 1'b1;
    cfg_wdata  = 8'h55;
    #1;
    check_eq("done_wready", 32'(cfg_wready), 32'd0);
    tick();
    cfg_wvalid = 1'b0;
    check_eq("done_wr_err", 32'(cfg_err), 32'd1);
    tick();
    check_eq("done_err_pulse", 32'(cfg_err), 32'd0);
    check_eq("done_no_shift", 32'(sh_cnt - b_sh), 32'd0);
    check_eq("done_hold", 32'(cfg_done), 32'd1);

    // Abort after 10 shifts, then a fresh load
    b_sh = sh_cnt; b_upd = upd_cnt;
    pulse_start();
    send_word(8'hA5);
    send_word(8'h3C);
    tick();
    pulse_start();
    check_eq("abort_shifts", 32'(sh_cnt - b_sh), 32'd10);
    check_eq("abort_err", 32'(cfg_err), 32'd1);
    check_eq("abort_shen", 32'(scan_shift_en), 32'd0);
    check_eq("abort_no_upd", 32'(upd_cnt - b_upd), 32'd0);
    b_sh = sh_cnt; b_upd = upd_cnt;
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hFF);
    wait_done();
    check_eq("reload_bits", bits_from(b_sh), ExpBits);
    check_eq("reload_count", 32'(sh_cnt - b_sh), 32'd20);
    check_eq("reload_upd", 32'(upd_cnt - b_upd), 32'd1);

    // Reset at bit 5
    b_sh = sh_cnt; b_upd = upd_cnt;
    pulse_start();
    send_word(8'hA5);
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre_rst_shen", 32'(scan_shift_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_outs", outs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_idle", 32'({cfg_busy, cfg_done, scan_shift_en}), 32'd0);
    check_eq("rst_no_upd", 32'(upd_cnt - b_upd), 32'd0);

    // Start colliding with a valid word in SHIFT
    pulse_start();
    send_word(8'hA5);
    cfg_start  = 1'b1;
    cfg_wvalid = 1'b1;
    cfg_wdata  = 8'h3C;
    #1;
    check_eq("coll_wready", 32'(cfg_wready), 32'd0);
    tick();
    cfg_start  = 1'b0;
    cfg_wvalid = 1'b0;
    check_eq("coll_err", 32'(cfg_err), 32'd1);
    check_eq("coll_shen", 32'(scan_shift_en), 32'd0);
    b_sh = sh_cnt; b_upd = upd_cnt;
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hFF);
    wait_done();
    check_eq("coll_bits", bits_from(b_sh), ExpBits);
    check_eq("coll_count", 32'(sh_cnt - b_sh), 32'd20);
    check_eq("coll_upd", 32'(upd_cnt - b_upd), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
